// File: rtl/pe_pkg.sv
// Shared types and constants for the systolic PE array feeders.
package pe_pkg;

  localparam int unsigned DW_DEF = 16;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StSkew,
    StStream,
    StDone
  } feeder_state_t;

endpackage

// File: rtl/pe_feed_buf.sv
// Operand row buffer: DEPTH x DW register file, one write port, one asynchronous read port.
module pe_feed_buf
  import pe_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [DW-1:0] rd_data
);

  // Contents survive reset so a row can be replayed after an abort.
  logic signed [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pe_row_feeder.sv
// Streams one buffered operand row into a PE operand FIFO after a start pulse and skew delay.
// Define FEEDER_STALL_CNT_EN to build the saturating backpressure stall counter.
module pe_row_feeder
  import pe_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned SW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic [7:0]           len,
  input  logic [SW-1:0]        skew,
  input  logic                 go,
  input  logic                 aff,
  output logic                 start,
  output logic signed [DW-1:0] d_out,
  output logic                 we,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_err,
  output logic [15:0]          stall_cnt
);

  feeder_state_t        state_q, state_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          eff_len_q, eff_len_d;
  logic [SW-1:0]        skew_cnt_q, skew_cnt_d;
  logic                 wr_err_q;
  logic signed [DW-1:0] d_hold_q;
  logic signed [DW-1:0] rd_data;
  logic                 go_acc;
  logic                 buf_we;

  assign busy   = (state_q != StIdle);
  assign wr_err = wr_err_q;
  assign buf_we = wr_en && !busy;

  pe_feed_buf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    eff_len_d  = eff_len_q;
    skew_cnt_d = skew_cnt_q;
    start      = 1'b0;
    we         = 1'b0;
    done       = 1'b0;
    go_acc     = 1'b0;
    d_out      = d_hold_q;
    unique case (state_q)
      StIdle: begin
        if (go && (len != 8'd0)) begin
          go_acc     = 1'b1;
          state_d    = StStart;
          eff_len_d  = (32'(len) > DEPTH) ? (AW+1)'(DEPTH) : len[AW:0];
          skew_cnt_d = skew;
          rd_ptr_d   = '0;
        end
      end
      StStart: begin
        start   = 1'b1;
        state_d = (skew_cnt_q != '0) ? StSkew : StStream;
      end
      StSkew: begin
        if (skew_cnt_q == SW'(1)) begin
          state_d = StStream;
        end else begin
          skew_cnt_d = skew_cnt_q - SW'(1);
        end
      end
      StStream: begin
        d_out = rd_data;
        we    = !aff;
        if (we) begin
          // Last word leaves rd_ptr in place so it never wraps within a stream.
          if ({1'b0, rd_ptr_q} == (eff_len_q - (AW+1)'(1))) begin
            state_d = StDone;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      eff_len_q  <= '0;
      skew_cnt_q <= '0;
      wr_err_q   <= 1'b0;
      d_hold_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      eff_len_q  <= eff_len_d;
      skew_cnt_q <= skew_cnt_d;
      if (go_acc) begin
        wr_err_q <= 1'b0;
      end else if (wr_en && busy) begin
        wr_err_q <= 1'b1;
      end
      if (state_q == StStream) begin
        d_hold_q <= rd_data;
      end
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (go_acc) begin
      stall_q <= '0;
    end else if ((state_q == StStream) && aff && (stall_q != STALL_MAX)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: doc/pe_row_feeder.md
Name: pe_row_feeder

Overview:
- Upstream stage of the systolic PE array: buffers one operand row (A or B side) and streams it into a PE's operand input FIFO.
- The CPU/bus side fills a local buffer, sets the length and skew, then pulses go.
- The feeder issues the PE start pulse, waits the systolic skew for its row/column index, then drives data plus write-enable under the PE's FIFO-full backpressure.
- One instance per array edge row or column.

Parameters:
DW, 16, operand width (signed)
DEPTH, 16, buffer entries
AW, 4, buffer address width, log2(DEPTH)
SW, 4, skew counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  AW  buffer write address
wr_data  in  DW  buffer write data (signed)
len  in  8  words to stream; sampled at go
skew  in  SW  idle cycles between start and first word; sampled at go
go  in  1  launch pulse
aff  in  1  PE operand FIFO full (backpressure)
start  out  1  one-cycle start pulse to PE
d_out  out  DW  operand to PE a_in/b_in
we  out  1  operand write enable to PE awe/bwe
busy  out  1  high from accepted go until done
done  out  1  one-cycle completion pulse
wr_err  out  1  sticky: write attempted while busy
stall_cnt  out  16  backpressure stall count (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous, active-low.
- Reset (rst_n=0 sampled at posedge): state=IDLE, rd_ptr=0, counters=0. start, we, busy, done, wr_err=0; d_out=0; stall_cnt=0. Buffer contents are not reset.
- Reset mid-operation aborts immediately. No done pulse. Buffer contents are kept.
- Buffer writes:
  - wr_en with busy=0 writes buf[wr_addr]=wr_data at the clock edge.
  - wr_en with busy=1 is dropped and sets wr_err (cleared only by reset or an accepted go).
- FSM states: IDLE, START, SKEW, STREAM, DONE.
  - IDLE: go=1 and len!=0 → START. Latch eff_len=min(len,DEPTH), latch skew, rd_ptr=0, clear wr_err, busy=1 next cycle. go with len=0 is ignored (no start, no done).
  - START: start=1 for exactly this cycle. → SKEW if skew!=0, else → STREAM.
  - SKEW: down-counter loaded with skew; we=0. → STREAM the cycle after the count reaches 1, so exactly skew cycles are spent in SKEW.
  - STREAM:
    - we = !aff, combinational. d_out = buf[rd_ptr], combinational read.
    - On a cycle with we=1, rd_ptr increments.
    - When the word at index eff_len-1 is issued → DONE.
    - aff=1 holds rd_ptr and d_out; no word is lost or duplicated.
  - DONE: done=1 for one cycle, busy=0 next cycle, → IDLE.
- go while busy is ignored.
- Latency, no backpressure: start at cycle T+1 after go at T; first we at T+2+skew; last we at T+1+skew+eff_len; done one cycle later.
- d_out outside STREAM holds its last driven value; we=0 outside STREAM.
- Width rules: data is passed through unmodified (signed DW). eff_len clamps at DEPTH. rd_ptr never wraps within one stream.

Optional Feature:
- Macro: FEEDER_STALL_CNT_EN.
- Defined: stall_cnt increments on each STREAM cycle with aff=1, saturates at 16'hFFFF, and clears on an accepted go or reset.
- Undefined: counter logic is omitted and stall_cnt is tied to 0. The port is still present.

Decomposition:
- Shared package pe_pkg:
  - DW default
  - FSM state enum, feeder_state_t (IDLE/START/SKEW/STREAM/DONE)
  - constant STALL_MAX=16'hFFFF
- One natural sub-module: pe_feed_buf (DEPTH x DW register file, 1 write port, 1 async read port).
- Sequencer FSM stays in pe_row_feeder.

Test Plan:
- Basic stream: load buf[0..4]={10,20,30,255,20}, len=5, skew=0, aff=0, go → start one cycle later, then we high 5 consecutive cycles with d_out 10,20,30,255,20, then done pulse; busy spans go+1..done.
- Skew: same data, skew=3 → exactly 3 cycles of we=0 between the start cycle and the first we.
- Backpressure: len=4, aff forced high for 2 cycles after the second word → d_out holds the third word, then 4 words total, in order, no duplicates; with FEEDER_STALL_CNT_EN, stall_cnt=2.
- Boundaries:
  - go with len=0 → no start, no done.
  - len=20 → exactly 16 words streamed.
  - Second go while busy → ignored.
- Write while busy: wr_en during STREAM → buffer unchanged, wr_err=1 until next go.
- Reset mid-stream: rst_n low during STREAM → next edge all outputs 0, state IDLE, no done; a following go with len=5 streams buffer data intact.
